fir_decimating_output_stage: RTL and testbench
==============================================

# fir_decimating_output_stage

Downstream stage of the direct-form FIR filter. Takes the filter's 32-bit signed output and drops the startup transient while the delay line fills. It then decimates by a fixed factor, saturates each kept sample to a narrower signed width, and buffers the result in a small FIFO. The FIFO drives a valid/ready stream towards the consumer (DAC packer or DMA).

## Interface
- `IN_WIDTH`, 32: width of the filter output sample (signed, two's complement).
- `OUT_WIDTH`, 16: width of the output sample (signed); must be less than or equal to IN_WIDTH.
- `DECIM`, 4: decimation factor, at least 1; 1 means keep every sample.
- `WARMUP`, 20: accepted samples discarded after reset; set equal to the filter order.
- `FIFO_DEPTH`, 8: FIFO entries, a power of two, at least 2.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `in_valid`  in  1: `in_sample` carries a new filter output this cycle (sample strobe).
- `in_sample`  in  IN_WIDTH: signed filter output.
- `out_data`  out  OUT_WIDTH: FIFO head sample; reset value 0.
- `out_valid`  out  1: FIFO not empty; reset value 0.
- `out_ready`  in  1: consumer accepts `out_data` when both `out_valid` and `out_ready` are high.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: current occupancy; reset value 0.
- `sat_flag`  out  1: sticky; set when any kept sample was clipped; reset value 0.
- `overflow_count`  out  16: kept samples dropped because the FIFO was full; saturates at 0xFFFF; reset value 0.

## Operation
- **Phase FSM.** States are WARMUP and RUN, with reset entering WARMUP.
  - In WARMUP, a warmup counter increments on each `in_valid`.
  - When the WARMUP-th sample is accepted, the FSM moves to RUN on that edge; that sample is discarded.
  - If WARMUP is 0, the FSM enters RUN directly after reset.
- **Decimation.** The phase counter runs 0..DECIM-1 and advances only on `in_valid` while in RUN.
  - A sample is kept when phase equals 0.
  - Phase wraps from DECIM-1 back to 0.
  - The first sample in RUN is therefore kept.
- **Saturation.** Applied to kept samples only.
  - A sample greater than 2^(OUT_WIDTH-1)-1 is clamped to that value.
  - A sample less than -2^(OUT_WIDTH-1) is clamped to that value.
  - Otherwise the sample is truncated to its low OUT_WIDTH bits, with no rounding.
  - Any clip sets `sat_flag`.
- **Stage register.** Holds the saturated sample plus a keep bit. Writes into the FIFO come only from this register.
- **FIFO write rule.** When keep is high:
  - FIFO not full: write the sample.
  - FIFO full and a read occurs in the same cycle: write the sample; the level is unchanged.
  - FIFO full and no read: drop the sample and increment `overflow_count`.
- **FIFO read.** A read occurs on `out_valid && out_ready`; the head advances on the next edge.
- **Stream rule.** While `out_valid` is high, `out_data` stays stable until the handshake completes.
- **Reset mid-operation.**
  - FIFO contents are discarded and all counters and flags cleared.
  - The FSM returns to WARMUP.
  - `out_valid` is 0 in the cycle after the reset edge.

## Timing
- **Latency.** A sample presented with `in_valid` in cycle N is captured into the stage register at edge N. It is written into the FIFO at edge N+1. `out_valid` and `out_data` reflect it in cycle N+1, after that edge.
  - Into an empty FIFO this gives a latency of 2 edges.
- **Throughput.** One kept sample per cycle, which requires DECIM=1 and `out_ready` held high continuously.
- **Status outputs.**
  - `fifo_level` updates on the same edge as the write or read.
  - `overflow_count` and `sat_flag` update on the edge at which the stage register is evaluated, N+1.
- **No backpressure upstream.** The filter cannot stall; data loss is visible only via `overflow_count`.

## Structure
- **Shared package `fir_pkg`.**
  - Phase enum `fir_out_state_t` {WARMUP, RUN}.
  - Constants for default sample widths, IN_W=32 and OUT_W=16.
  - Pure function `fir_saturate(in, out_width)`, reused by later stages.
- **Sub-module `fir_sample_fifo`.** Parameterised synchronous FIFO with:
  - inputs `wr_en`, `wr_data`, `rd_en`;
  - outputs `rd_data`, `empty`, `full`, `level`;
  - same-cycle read and write allowed when full;
  - read data taken from the head entry and valid whenever `empty` is low.
- **Top level.** Holds the FSM, counters, saturation, stage register and overflow logic.

## Test plan
1. **Warmup and decimation.** Reset, then `in_valid` high continuously with `in_sample` = index 0,1,2,…; `out_ready`=1 and defaults. Required: outputs are 20, 24, 28, …. The first `out_valid` rises 2 edges after the cycle presenting sample 20.
2. **Saturation.** With DECIM=1 and WARMUP=0, feed 32767, 32768, -32768, -40000, 0x0001_2345. Required: outputs 32767, 32767, -32768, -32768, 32767. `sat_flag` is set at the second sample and stays set.
3. **Backpressure and overflow.** With DECIM=1, WARMUP=0 and `out_ready`=0, feed 12 samples. Required: `fifo_level` reaches 8 and `overflow_count` reaches 4. Then raise `out_ready`; the first 8 samples drain in order.
4. **Full with simultaneous read and write.** Fill the FIFO, then hold `out_ready`=1 and keep feeding. Required: `fifo_level` stays at 8, `overflow_count` does not change, and the output sequence has no gaps.
5. **Stream stability.** Toggle `out_ready` pseudo-randomly. Required: `out_data` never changes while `out_valid` is high and `out_ready` is low, with no loss and no duplication.
6. **Reset mid-stream.** Assert `reset` for 1 cycle while the FIFO holds 5 samples. Required: the next cycle shows `out_valid`=0, `fifo_level`=0 and `overflow_count`=0. WARMUP then restarts, so the first output after reset is the 21st post-reset sample.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path: phase enum, default sample
// widths and a saturation helper reused by later stages.
// Ports: none (package).
package fir_pkg;

  // Output-stage phase: discard the startup transient, then stream.
  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } fir_out_state_t;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  // Clamp a signed value into the signed range of out_width bits. The result
  // stays in 64-bit form so callers of any width can slice the low bits and
  // detect clipping by comparing against the original value.
  function automatic logic signed [63:0] fir_saturate(
    input logic signed [63:0] in_val,
    input int                 out_width
  );
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_width - 1));
    if (in_val > max_v) begin
      return max_v;
    end else if (in_val < min_v) begin
      return min_v;
    end else begin
      return in_val;
    end
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous FIFO for decimated samples; head entry readable whenever not empty.
// Ports: wr_en/wr_data push, rd_en pops the head, rd_data/empty/full/level report state.
// A write while full is accepted only if a read happens in the same cycle.
module fir_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_rd   = rd_en && !empty;
  // The freed head slot makes room for the incoming write when full.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fir_decimating_output_stage.sv
// FIR output stage: drop WARMUP transient samples, decimate by DECIM, saturate
// to OUT_WIDTH, stage, then buffer in a FIFO feeding a valid/ready stream.
// Ports: clk/reset; in_valid/in_sample from the filter; out_data/out_valid/out_ready
// stream; fifo_level, sticky sat_flag and saturating overflow_count status.
module fir_decimating_output_stage
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = IN_W,
  parameter int OUT_WIDTH  = OUT_W,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_sample,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic [15:0]                   overflow_count
);

  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [WCW-1:0] WARM_LAST  = (WARMUP > 0) ? WCW'(WARMUP - 1) : '0;
  localparam logic [WCW-1:0] WARM_ONE   = WCW'(1);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(DECIM - 1);
  localparam logic [PW-1:0]  PHASE_ONE  = PW'(1);

  // The WARMUP parameter shadows the package enum literal of the same name,
  // so the phase states are always referenced through the package scope.
  fir_out_state_t state_q;
  fir_out_state_t state_d;
  logic           keep_d;

  logic [WCW-1:0] warm_cnt;
  logic [PW-1:0]  phase;

  logic signed [IN_WIDTH-1:0] in_s;
  logic signed [63:0]         in_ext;
  logic signed [63:0]         sat_ext;
  logic [OUT_WIDTH-1:0]       sat_val;
  logic                       clip;

  logic                 stg_keep;
  logic [OUT_WIDTH-1:0] stg_data;
  logic                 stg_clip;

  logic                 rd_fire;
  logic                 fifo_wr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 drop;
  logic [OUT_WIDTH-1:0] fifo_rd_data;

  // ---------------- phase FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      if (WARMUP == 0) state_q <= fir_pkg::RUN;
      else             state_q <= fir_pkg::WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    keep_d  = 1'b0;
    case (state_q)
      fir_pkg::WARMUP: begin
        // The sample that completes warmup is itself discarded.
        if (in_valid && (warm_cnt == WARM_LAST)) state_d = fir_pkg::RUN;
      end
      fir_pkg::RUN: begin
        keep_d = in_valid && (phase == '0);
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if ((state_q == fir_pkg::WARMUP) && in_valid) begin
      warm_cnt <= warm_cnt + WARM_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if ((state_q == fir_pkg::RUN) && in_valid) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_ONE;
    end
  end

  // ---------------- saturation ----------------
  assign in_s    = in_sample;
  assign in_ext  = 64'(in_s);
  assign sat_ext = fir_saturate(in_ext, OUT_WIDTH);
  assign sat_val = sat_ext[OUT_WIDTH-1:0];
  assign clip    = (sat_ext != in_ext);

  // ---------------- stage register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_keep <= 1'b0;
      stg_data <= '0;
      stg_clip <= 1'b0;
    end else begin
      stg_keep <= keep_d;
      if (keep_d) begin
        stg_data <= sat_val;
        stg_clip <= clip;
      end
    end
  end

  // ---------------- FIFO write / overflow ----------------
  assign rd_fire = out_valid && out_ready;
  assign fifo_wr = stg_keep && (!fifo_full || rd_fire);
  assign drop    = stg_keep && fifo_full && !rd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag       <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (stg_keep && stg_clip) sat_flag <= 1'b1;
      if (drop && (overflow_count != 16'hFFFF)) overflow_count <= overflow_count + 16'd1;
    end
  end

  fir_sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (stg_data),
    .rd_en   (rd_fire),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign out_valid = !fifo_empty;
  // Unwritten storage is hidden so the idle stream reads as zero.
  assign out_data  = fifo_empty ? '0 : fifo_rd_data;

endmodule

// File: tb/tb_fir_decimating_output_stage.sv
// Bench for the FIR output stage: default instance (DECIM=4, WARMUP=20) and a
// DECIM=1/WARMUP=0 instance, checked against scoreboards of expected samples.
module tb_fir_decimating_output_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        ra, iva, ora;
  logic [31:0] isa;
  logic [15:0] oda, ocb_unused;
  logic        ova, sfa;
  logic [3:0]  la;
  logic [15:0] oca;

  // Instance B: DECIM=1, WARMUP=0
  logic        rb, ivb, orb;
  logic [31:0] isb;
  logic [15:0] odb;
  logic        ovb, sfb;
  logic [3:0]  lb;
  logic [15:0] ocb;

  fir_decimating_output_stage u_dut_a (
    .clk(clk), .reset(ra), .in_valid(iva), .in_sample(isa),
    .out_data(oda), .out_valid(ova), .out_ready(ora),
    .fifo_level(la), .sat_flag(sfa), .overflow_count(oca)
  );

  fir_decimating_output_stage #(.DECIM(1), .WARMUP(0)) u_dut_b (
    .clk(clk), .reset(rb), .in_valid(ivb), .in_sample(isb),
    .out_data(odb), .out_valid(ovb), .out_ready(orb),
    .fifo_level(lb), .sat_flag(sfb), .overflow_count(ocb)
  );

  int passed = 0;
  int total  = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic bit kept_a(input int i);
    return (i >= 20) && (((i - 20) % 4) == 0);
  endfunction

  // Monitor A: scoreboard pops plus hold check while stalled.
  logic        pa_vld = 1'b0, pa_rdy = 1'b0, pa_rst = 1'b1;
  logic [15:0] pa_dat = '0;
  logic [15:0] exp_a, exp_b;
  always @(negedge clk) begin
    if (pa_vld && !pa_rdy && !pa_rst) begin
      check("a_hold_vld", ova, 1);
      check("a_hold_dat", oda, pa_dat);
    end
    if (!ra && ova && ora) begin
      check("a_sb_nonempty", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        exp_a = qa.pop_front();
        check("a_out", oda, exp_a);
      end
    end
    pa_vld = ova;
    pa_rdy = ora;
    pa_rst = ra;
    pa_dat = oda;
  end

  // Monitor B: scoreboard pops.
  always @(negedge clk) begin
    if (!rb && ovb && orb) begin
      check("b_sb_nonempty", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        exp_b = qb.pop_front();
        check("b_out", odb, exp_b);
      end
    end
  end

  logic [31:0] t2_in  [5] = '{32'd32767, 32'd32768, 32'hFFFF_8000, 32'hFFFF_63C0, 32'h0001_2345};
  logic [15:0] t2_exp [5] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};

  initial begin
    int v;
    ra = 1'b1; iva = 1'b0; isa = '0; ora = 1'b0;
    rb = 1'b1; ivb = 1'b0; isb = '0; orb = 1'b0;
    ocb_unused = '0;
    tick(); tick();
    mid();
    check("rst_a_valid", ova, 0);
    check("rst_a_level", la, 0);
    check("rst_a_ovf", oca, 0);
    check("rst_a_sat", sfa, 0);
    check("rst_a_data", oda, 0);
    check("rst_b_valid", ovb, 0);
    check("rst_b_level", lb, 0);
    tick();
    ra = 1'b0; rb = 1'b0;

    // 1: warmup and decimation, first-valid timing
    ora = 1'b1;
    for (int i = 0; i < 64; i++) begin
      iva = 1'b1; isa = 32'(i);
      if (kept_a(i)) qa.push_back(16'(i));
      mid();
      if (i <= 22) check("t1_first_valid", ova, 32'(i >= 22));
      tick();
    end
    iva = 1'b0;
    repeat (8) tick();
    mid();
    check("t1_drained", qa.size(), 0);
    check("t1_idle_valid", ova, 0);
    tick();

    // 2: saturation on instance B
    rb = 1'b1; qb.delete(); tick(); rb = 1'b0; orb = 1'b1;
    for (int j = 0; j < 5; j++) begin
      ivb = 1'b1; isb = t2_in[j];
      qb.push_back(t2_exp[j]);
      mid();
      check("t2_sat_flag", sfb, 32'(j >= 3));
      tick();
    end
    ivb = 1'b0;
    repeat (4) tick();
    mid();
    check("t2_sat_sticky", sfb, 1);
    check("t2_drained", qb.size(), 0);
    check("t2_ovf", ocb, 0);
    tick();

    // 3: backpressure and overflow
    rb = 1'b1; qb.delete(); tick(); rb = 1'b0; orb = 1'b0;
    for (int j = 0; j < 12; j++) begin
      ivb = 1'b1; isb = 32'(100 + j);
      if (j < 8) qb.push_back(16'(100 + j));
      tick();
    end
    ivb = 1'b0;
    tick(); tick();
    mid();
    check("t3_level_full", lb, 8);
    check("t3_ovf", ocb, 4);
    check("t3_valid", ovb, 1);
    check("t3_head", odb, 100);
    tick();
    orb = 1'b1;
    repeat (10) tick();
    mid();
    check("t3_drained", qb.size(), 0);
    check("t3_level_empty", lb, 0);
    check("t3_ovf_hold", ocb, 4);
    tick();

    // 4: full FIFO with simultaneous read and write
    rb = 1'b1; qb.delete(); tick(); rb = 1'b0; orb = 1'b0;
    for (int j = 0; j < 41; j++) begin
      ivb = 1'b1; isb = 32'(200 + j);
      orb = (j >= 9);
      qb.push_back(16'(200 + j));
      mid();
      if (j >= 9) begin
        check("t4_level", lb, 8);
        check("t4_ovf", ocb, 0);
      end
      tick();
    end
    ivb = 1'b0;
    repeat (12) tick();
    mid();
    check("t4_drained", qb.size(), 0);
    check("t4_ovf_end", ocb, 0);
    tick();

    // 5: random out_ready, stream stability
    ra = 1'b1; qa.delete(); tick(); ra = 1'b0;
    for (int i = 0; i < 220; i++) begin
      v = i * 37 - 3000;
      iva = 1'b1; isa = v;
      ora = 1'($urandom_range(0, 1));
      if (kept_a(i)) qa.push_back(v[15:0]);
      tick();
    end
    iva = 1'b0; ora = 1'b1;
    repeat (12) tick();
    mid();
    check("t5_drained", qa.size(), 0);
    check("t5_ovf", oca, 0);
    tick();

    // 6: reset mid-stream with 5 samples buffered
    ra = 1'b1; qa.delete(); tick(); ra = 1'b0; ora = 1'b0;
    for (int i = 0; i < 37; i++) begin
      iva = 1'b1; isa = 32'(i);
      if (kept_a(i)) qa.push_back(16'(i));
      tick();
    end
    iva = 1'b0;
    tick(); tick();
    mid();
    check("t6_level_pre", la, 5);
    tick();
    ra = 1'b1; qa.delete();
    tick();
    ra = 1'b0;
    mid();
    check("t6_valid_post", ova, 0);
    check("t6_level_post", la, 0);
    check("t6_ovf_post", oca, 0);
    tick();
    ora = 1'b1;
    for (int i = 0; i < 41; i++) begin
      iva = 1'b1; isa = 32'(1000 + i);
      if (kept_a(i)) qa.push_back(16'(1000 + i));
      tick();
    end
    iva = 1'b0;
    repeat (10) tick();
    mid();
    check("t6_drained", qa.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
